l1_miss_handler: RTL
====================

L1_MISS_HANDLER -- requirements
Module: l1_miss_handler

Interface
REQ-001 Parameters SHALL be: BW_USED_ADDR_WORD, default 24, word address width; BW_DATA_EXTERNAL_BUS, default 512, block width; BW_CACHE_COMMAND, default 3, command width; BW_CONFIG_REGS, default 32, counter width.
REQ-002 Ports SHALL be, in order:
- clock_i  in  1  sole clock.
- resetn_i  in  1  reset, asynchronous, active-low.
- miss_req_i  in  1  L1 miss request, sampled only while ready_o=1.
- miss_addr_i  in  BW_USED_ADDR_WORD  missing word address.
- victim_dirty_i  in  1  victim line needs writeback.
- victim_addr_i  in  BW_USED_ADDR_WORD  victim word address.
- victim_data_i  in  BW_DATA_EXTERNAL_BUS  victim block.
- ready_o  out  1  handler idle, accepts a miss.
- external_write_o  out  1  request strobe to next level.
- external_command_o  out  BW_CACHE_COMMAND  request command.
- external_addr_o  out  BW_USED_ADDR_WORD  block-aligned request address.
- external_data_o  out  BW_DATA_EXTERNAL_BUS  request block.
- external_full_i  in  1  next-level request buffer full.
- external_write_i  in  1  service strobe from next level.
- external_command_i  in  BW_CACHE_COMMAND  service command.
- external_addr_i  in  BW_USED_ADDR_WORD  service address.
- external_data_i  in  BW_DATA_EXTERNAL_BUS  service block.
- external_full_o  out  1  handler cannot accept a service.
- fill_valid_o  out  1  one-cycle line-fill strobe.
- fill_addr_o  out  BW_USED_ADDR_WORD  block-aligned fill address.
- fill_data_o  out  BW_DATA_EXTERNAL_BUS  fill block.
- resp_error_o  out  1  sticky protocol error.
- miss_count_o  out  BW_CONFIG_REGS  completed misses.
- stall_cycles_o  out  BW_CONFIG_REGS  cycles spent outside ST_IDLE.

Function
REQ-003 Every output SHALL be registered; none SHALL combinationally depend on an input.
REQ-004 States SHALL be ST_IDLE, ST_SEND_WB, ST_SEND_RD, ST_WAIT_RESP, ST_FILL.
REQ-005 ready_o SHALL be 1 only in ST_IDLE; external_full_o SHALL be 0 only in ST_WAIT_RESP.
REQ-006 ST_IDLE with miss_req_i=1: latch miss and victim inputs; go to ST_SEND_WB if victim_dirty_i=1, else to ST_SEND_RD.
REQ-007 Addresses SHALL be block-aligned by forcing the low 4 word-address bits to zero (16 words per block).
REQ-008 ST_SEND_WB with external_full_i=0: pulse external_write_o for one cycle with CACHE_REQUEST_WRITEOUT_BLOCK, the aligned victim address and victim data; go to ST_SEND_RD. With external_full_i=1: hold the state, no strobe.
REQ-009 ST_SEND_RD with external_full_i=0: pulse external_write_o with CACHE_REQUEST_READIN_BLOCK, the aligned miss address and all-zero data; go to ST_WAIT_RESP. Otherwise hold.
REQ-010 ST_WAIT_RESP: external_write_i=1 with CACHE_SERVICE_READIN_BLOCK and an aligned address equal to the latched aligned miss address SHALL capture external_data_i and go to ST_FILL.
REQ-011 A mismatched command or address in ST_WAIT_RESP SHALL be discarded and set resp_error_o; the state is held.
REQ-012 external_write_i=1 in any state other than ST_WAIT_RESP SHALL set resp_error_o and be ignored.
REQ-013 ST_FILL: pulse fill_valid_o for one cycle with the aligned miss address and the captured data; increment miss_count_o; return to ST_IDLE. A new miss SHALL be accepted no earlier than the following cycle.
REQ-014 stall_cycles_o SHALL increment on every cycle spent outside ST_IDLE.
REQ-015 Both counters SHALL saturate at all-ones and never wrap.
REQ-016 resp_error_o SHALL clear only on reset.
REQ-017 Minimum miss latency, clean victim, no backpressure, same-cycle service: accept at cycle 0, READIN strobe at 1, fill_valid_o at 3.

Reset
REQ-018 resetn_i=0 SHALL asynchronously force: state ST_IDLE; all strobes, addresses, data, commands, counters and resp_error_o to 0; ready_o=1; external_full_o=1.
REQ-019 A reset during any transfer SHALL abandon it with no strobe issued, and latched data SHALL be discarded.

Structure
REQ-020 The macros CACHE_REQUEST_READIN_BLOCK, CACHE_REQUEST_WRITEOUT_BLOCK and CACHE_SERVICE_READIN_BLOCK and the state encodings SHALL come from the shared cache definitions header, not be redefined locally.
REQ-021 The block SHALL be a single flat module with no sub-modules.

Verification
REQ-022 Clean miss, address 0x000123, full_i=0, service returned at once -> READIN at address 0x000120, fill_valid_o with service data, miss_count_o=1.
REQ-023 Dirty miss, victim address 0x0004A7, miss address 0x000123 -> WRITEOUT at 0x0004A0 with victim data, next cycle READIN at 0x000120, then fill.
REQ-024 external_full_i=1 for 5 cycles in ST_SEND_RD -> no strobe during those cycles, READIN on the first cycle full_i=0, stall_cycles_o counts every waiting cycle.
REQ-025 Service at address 0x000200 while waiting on 0x000120 -> resp_error_o=1, no fill; the later correct service completes the fill.
REQ-026 resetn_i=0 in ST_WAIT_RESP, then a service arrives after reset -> no fill, ready_o=1, resp_error_o=1.
REQ-027 Counters preloaded near all-ones via forced stimulus -> saturate at 0xFFFFFFFF.

Source files
------------

// File: rtl/l1_miss_handler_pkg.sv
// Shared cache definitions: command encodings and miss-handler state encodings.
package l1_miss_handler_pkg;

  localparam logic [2:0] CACHE_REQUEST_READIN_BLOCK   = 3'd1;
  localparam logic [2:0] CACHE_REQUEST_WRITEOUT_BLOCK = 3'd2;
  localparam logic [2:0] CACHE_SERVICE_READIN_BLOCK   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_WB,
    ST_SEND_RD,
    ST_WAIT_RESP,
    ST_FILL
  } state_t;

endpackage

// File: rtl/l1_miss_handler.sv
// L1 miss handler: optional victim writeback, block read request, response wait and line fill.
// All outputs come straight from flops; handshake flags are loaded from the next state.
module l1_miss_handler
  import l1_miss_handler_pkg::*;
#(
  parameter int BW_USED_ADDR_WORD    = 24,
  parameter int BW_DATA_EXTERNAL_BUS = 512,
  parameter int BW_CACHE_COMMAND     = 3,
  parameter int BW_CONFIG_REGS       = 32
) (
  input  logic                            clock_i,
  input  logic                            resetn_i,
  input  logic                            miss_req_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    miss_addr_i,
  input  logic                            victim_dirty_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    victim_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] victim_data_i,
  output logic                            ready_o,
  output logic                            external_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     external_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    external_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] external_data_o,
  input  logic                            external_full_i,
  input  logic                            external_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     external_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    external_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] external_data_i,
  output logic                            external_full_o,
  output logic                            fill_valid_o,
  output logic [BW_USED_ADDR_WORD-1:0]    fill_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] fill_data_o,
  output logic                            resp_error_o,
  output logic [BW_CONFIG_REGS-1:0]       miss_count_o,
  output logic [BW_CONFIG_REGS-1:0]       stall_cycles_o
);

  // Sixteen words per block: the low four word-address bits select the word.
  localparam logic [BW_USED_ADDR_WORD-1:0] OFFSET_MASK = BW_USED_ADDR_WORD'(4'hF);

  function automatic logic [BW_USED_ADDR_WORD-1:0] align(input logic [BW_USED_ADDR_WORD-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

  state_t state, next_state;

  logic [BW_USED_ADDR_WORD-1:0]    miss_addr_q;
  logic [BW_USED_ADDR_WORD-1:0]    victim_addr_q;
  logic [BW_DATA_EXTERNAL_BUS-1:0] victim_data_q;
  logic                            svc_hit;

  assign svc_hit = (state == ST_WAIT_RESP) && external_write_i &&
                   (external_command_i == BW_CACHE_COMMAND'(CACHE_SERVICE_READIN_BLOCK)) &&
                   (align(external_addr_i) == miss_addr_q);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (miss_req_i) next_state = victim_dirty_i ? ST_SEND_WB : ST_SEND_RD;
      ST_SEND_WB:   if (!external_full_i) next_state = ST_SEND_RD;
      ST_SEND_RD:   if (!external_full_i) next_state = ST_WAIT_RESP;
      ST_WAIT_RESP: if (svc_hit) next_state = ST_FILL;
      ST_FILL:      next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) state <= ST_IDLE;
    else           state <= next_state;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ready_o            <= 1'b1;
      external_full_o    <= 1'b1;
      external_write_o   <= 1'b0;
      external_command_o <= '0;
      external_addr_o    <= '0;
      external_data_o    <= '0;
      fill_valid_o       <= 1'b0;
      fill_addr_o        <= '0;
      fill_data_o        <= '0;
      resp_error_o       <= 1'b0;
      miss_count_o       <= '0;
      stall_cycles_o     <= '0;
      miss_addr_q        <= '0;
      victim_addr_q      <= '0;
      victim_data_q      <= '0;
    end else begin
      ready_o          <= (next_state == ST_IDLE);
      external_full_o  <= (next_state != ST_WAIT_RESP);
      external_write_o <= 1'b0;
      fill_valid_o     <= 1'b0;

      case (state)
        ST_IDLE: if (miss_req_i) begin
          miss_addr_q   <= align(miss_addr_i);
          victim_addr_q <= align(victim_addr_i);
          victim_data_q <= victim_data_i;
        end
        ST_SEND_WB: if (!external_full_i) begin
          external_write_o   <= 1'b1;
          external_command_o <= BW_CACHE_COMMAND'(CACHE_REQUEST_WRITEOUT_BLOCK);
          external_addr_o    <= victim_addr_q;
          external_data_o    <= victim_data_q;
        end
        ST_SEND_RD: if (!external_full_i) begin
          external_write_o   <= 1'b1;
          external_command_o <= BW_CACHE_COMMAND'(CACHE_REQUEST_READIN_BLOCK);
          external_addr_o    <= miss_addr_q;
          external_data_o    <= '0;
        end
        ST_WAIT_RESP: if (svc_hit) begin
          fill_addr_o <= miss_addr_q;
          fill_data_o <= external_data_i;
        end
        ST_FILL: begin
          fill_valid_o <= 1'b1;
          if (miss_count_o != '1) miss_count_o <= miss_count_o + BW_CONFIG_REGS'(1);
        end
        default: ;
      endcase

      // Any service that is not the awaited block is dropped and flagged for good.
      if (external_write_i && !svc_hit) resp_error_o <= 1'b1;

      if (state != ST_IDLE && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + BW_CONFIG_REGS'(1);
    end
  end

endmodule
